// File: rtl/rr_elastic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_elastic_arbiter
//  Description : Round-robin arbiter that shares one registered elastic
//                output stage among N valid/ready requesters. Each accepted
//                beat is registered together with the index of the requester
//                that supplied it. The grant stays on the current owner for
//                up to MAX_BURST consecutive beats while it keeps requesting.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_elastic_arbiter #(
    parameter int N         = 4,
    parameter int W         = 32,
    parameter int MAX_BURST = 1,
    parameter int IW        = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   t_data,
    input  logic [N-1:0]     t_valid,
    output logic [N-1:0]     t_ready,
    output logic [W-1:0]     i0_data,
    output logic             i0_valid,
    output logic [IW-1:0]    i0_id,
    input  logic             i0_ready
);

    localparam logic [7:0]    c_max_burst  = 8'(MAX_BURST);
    localparam logic [IW-1:0] c_owner_rst  = IW'(N - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [IW-1:0] r_owner;   // last requester that transferred
    logic [7:0]    r_cnt;     // consecutive beats in the current burst
    logic          r_open;    // a burst is in progress and may be extended
    logic [W-1:0]  r_data;
    logic [IW-1:0] r_id;
    logic          r_valid;

    // ------------------------------------------------------------------------
    // Combinational selection
    // ------------------------------------------------------------------------
    logic          w_load;
    logic          w_any;
    logic          w_hold;
    logic          w_xfer;
    logic [IW-1:0] w_search;
    logic [IW-1:0] w_cand;
    logic          w_found;
    logic [IW-1:0] w_sel;
    logic [W-1:0]  w_sel_data;

    // The output stage can accept when it is empty or being drained.
    assign w_load = ~r_valid | i0_ready;
    assign w_any  = |t_valid;
    assign w_xfer = w_load & w_any;

    // r_open is cleared at reset and after an idle load cycle, so a burst
    // only continues across back-to-back grants of the same owner. This is
    // what makes the first search after reset start at requester 0 and what
    // restarts the count after the owner drops its request.
    assign w_hold = t_valid[r_owner] & r_open & (r_cnt < c_max_burst);

    // Rotating priority search: owner+1, owner+2, ... wrapping, ending at owner.
    always_comb begin
        w_search = r_owner;
        w_cand   = '0;
        w_found  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            w_cand = IW'((int'(r_owner) + i) % N);
            if (!w_found && t_valid[w_cand]) begin
                w_found  = 1'b1;
                w_search = w_cand;
            end
        end
    end

    assign w_sel      = w_hold ? r_owner : w_search;
    assign w_sel_data = t_data[w_sel*W +: W];

    // One-hot ready towards the selected requester; zero when stalled or idle.
    generate
        for (genvar k = 0; k < N; k++) begin : g_ready
            assign t_ready[k] = w_xfer & (w_sel == IW'(k));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output stage and arbitration state update
    // ------------------------------------------------------------------------
    // Register the granted beat, or empty the stage when nothing is offered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_owner <= c_owner_rst;
            r_cnt   <= 8'd0;
            r_open  <= 1'b0;
        end else if (w_load) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_sel_data;
                r_id    <= w_sel;
                r_owner <= w_sel;
                r_cnt   <= w_hold ? (r_cnt + 8'd1) : 8'd1;
                r_open  <= 1'b1;
            end else begin
                r_valid <= 1'b0;
                r_open  <= 1'b0;
            end
        end
    end

    assign i0_valid = r_valid;
    assign i0_data  = r_data;
    assign i0_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_rr_elastic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_elastic_arbiter
//  Description : Directed self-checking bench for rr_elastic_arbiter. Three
//                instances (MAX_BURST = 1, 3, 2) share all inputs; each
//                scenario resets them and checks the relevant instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_elastic_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] t_data;
    logic [N-1:0]   t_valid;
    logic           i0_ready;

    logic [N-1:0]   rdy1, rdy3, rdy2;
    logic [W-1:0]   dat1, dat3, dat2;
    logic           vld1, vld3, vld2;
    logic [IW-1:0]  id1, id3, id2;

    int n_checks;
    int n_errors;

    rr_elastic_arbiter #(.N(N), .W(W), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .t_data(t_data), .t_valid(t_valid), .t_ready(rdy1),
        .i0_data(dat1), .i0_valid(vld1), .i0_id(id1), .i0_ready(i0_ready)
    );
    rr_elastic_arbiter #(.N(N), .W(W), .MAX_BURST(3)) dut3 (
        .clk(clk), .rst(rst), .t_data(t_data), .t_valid(t_valid), .t_ready(rdy3),
        .i0_data(dat3), .i0_valid(vld3), .i0_id(id3), .i0_ready(i0_ready)
    );
    rr_elastic_arbiter #(.N(N), .W(W), .MAX_BURST(2)) dut2 (
        .clk(clk), .rst(rst), .t_data(t_data), .t_valid(t_valid), .t_ready(rdy2),
        .i0_data(dat2), .i0_valid(vld2), .i0_id(id2), .i0_ready(i0_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [IW-1:0] exp_id3 [7];
    logic [IW-1:0] exp_id1 [6];
    logic [W-1:0]  exp_dat1 [6];
    logic [7:0]    exp_cnt2 [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_id1  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_dat1 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 32'hA1};
        exp_id3  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        exp_cnt2 = '{8'd1, 8'd2, 8'd1, 8'd2};

        for (int k = 0; k < N; k++) t_data[k*W +: W] = 32'hA0 + k;
        rst      = 1'b1;
        t_valid  = 4'b1111;
        i0_ready = 1'b1;

        // ---------------- Reset ----------------
        tick();
        tick();
        chk("rst_valid", {31'd0, vld1}, 32'd0);
        chk("rst_data",  dat1, 32'd0);
        chk("rst_id",    {30'd0, id1}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_first_ready", {28'd0, rdy1}, 32'h1);

        // ---------------- Full contention ----------------
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_valid", {31'd0, vld1}, 32'd1);
            chk("rr_id",    {30'd0, id1}, {30'd0, exp_id1[i]});
            chk("rr_data",  dat1, exp_dat1[i]);
        end

        // ---------------- Backpressure ----------------
        tick();
        chk("bp_pre_id", {30'd0, id1}, 32'd2);
        i0_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {28'd0, rdy1}, 32'd0);
            tick();
            chk("bp_id",   {30'd0, id1}, 32'd2);
            chk("bp_data", dat1, 32'hA2);
            chk("bp_valid", {31'd0, vld1}, 32'd1);
        end
        i0_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, rdy1}, 32'h8);
        tick();
        chk("bp_next_id", {30'd0, id1}, 32'd3);

        // ---------------- Burst limit (MAX_BURST=3) ----------------
        rst     = 1'b1;
        t_valid = 4'b0011;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("burst3_id", {30'd0, id3}, {30'd0, exp_id3[i]});
            chk("burst3_valid", {31'd0, vld3}, 32'd1);
        end

        // ---------------- Lone owner with hold loss (MAX_BURST=2) ----------------
        rst     = 1'b1;
        t_valid = 4'b0100;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lone_id",  {30'd0, id2}, 32'd2);
            chk("lone_cnt", {24'd0, dut2.r_cnt}, {24'd0, exp_cnt2[i]});
        end
        t_valid = 4'b0000;
        tick();
        chk("lone_gap_valid", {31'd0, vld2}, 32'd0);
        t_valid = 4'b0100;
        tick();
        chk("lone_resume_valid", {31'd0, vld2}, 32'd1);
        chk("lone_resume_id",    {30'd0, id2}, 32'd2);
        chk("lone_resume_cnt",   {24'd0, dut2.r_cnt}, 32'd1);

        // ---------------- Sparse wrap and reset mid-stream ----------------
        rst     = 1'b1;
        t_valid = 4'b1000;
        tick();
        rst = 1'b0;
        tick();
        chk("wrap_owner3_id", {30'd0, id1}, 32'd3);
        t_valid = 4'b0010;
        #1;
        chk("wrap_ready", {28'd0, rdy1}, 32'h2);
        tick();
        chk("wrap_id",   {30'd0, id1}, 32'd1);
        chk("wrap_data", dat1, 32'hA1);
        rst = 1'b1;
        tick();
        chk("midrst_valid", {31'd0, vld1}, 32'd0);
        chk("midrst_id",    {30'd0, id1}, 32'd0);
        rst     = 1'b0;
        t_valid = 4'b0000;
        tick();
        chk("midrst_idle_valid", {31'd0, vld1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
